fft_seq_agu: RTL

FFT_SEQ_AGU -- requirements
Module: fft_seq_agu

---
 rtl/fft_seq_agu_if.sv | 45 ++++
 rtl/fft_seq_agu.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fft_seq_agu_if.sv
// Bus between fft_seq_agu and the FFT datapath/RAM wrapper.
// The stall input exists only when FFT_SEQ_AGU_STALL_EN is defined.
interface fft_seq_agu_if #(
    parameter int N_LOG2 = 11
);
    logic              start;
`ifdef FFT_SEQ_AGU_STALL_EN
    logic              stall;
`endif
    logic              busy;
    logic              done;
    logic              rdsel;
    logic [N_LOG2-1:0] adra_rd;
    logic [N_LOG2-1:0] adrb_rd;
    logic [N_LOG2-2:0] twiddleadr;
    logic              we0;
    logic              we1;
    logic [N_LOG2-1:0] adra_wr;
    logic [N_LOG2-1:0] adrb_wr;
    logic              outsel;

`ifdef FFT_SEQ_AGU_STALL_EN
    modport master (
        output start, stall,
        input  busy, done, rdsel, adra_rd, adrb_rd, twiddleadr,
        input  we0, we1, adra_wr, adrb_wr, outsel
    );
    modport slave (
        input  start, stall,
        output busy, done, rdsel, adra_rd, adrb_rd, twiddleadr,
        output we0, we1, adra_wr, adrb_wr, outsel
    );
`else
    modport master (
        output start,
        input  busy, done, rdsel, adra_rd, adrb_rd, twiddleadr,
        input  we0, we1, adra_wr, adrb_wr, outsel
    );
    modport slave (
        input  start,
        output busy, done, rdsel, adra_rd, adrb_rd, twiddleadr,
        output we0, we1, adra_wr, adrb_wr, outsel
    );
`endif
endinterface

// File: rtl/fft_seq_agu.sv
// Address generator for an in-place radix-2 FFT that ping-pongs between two RAM banks.
// Optional stall input enabled by defining FFT_SEQ_AGU_STALL_EN.
module fft_seq_agu #(
    parameter int N_LOG2   = 11,
    parameter int BFLY_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    fft_seq_agu_if.slave bus
);

    localparam int TW_W = N_LOG2 - 1;
    localparam int S_W  = $clog2(N_LOG2);
    localparam int C_W  = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

    localparam logic [S_W-1:0]  S_LAST      = S_W'(N_LOG2 - 1);
    localparam logic [TW_W-1:0] I_LAST      = '1;
    localparam logic [C_W-1:0]  CNT_MID_END = C_W'(BFLY_LAT - 1);
    localparam logic [C_W-1:0]  CNT_FIN_END = C_W'((BFLY_LAT > 1) ? BFLY_LAT - 2 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic              vld;
        logic              bank;
        logic [N_LOG2-1:0] a;
        logic [N_LOG2-1:0] b;
    } wr_t;

    logic [1:0]      state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [TW_W-1:0] i_q, i_d;
    logic [C_W-1:0]  cnt_q, cnt_d;
    logic            rdsel_q, rdsel_d;
    wr_t             pipe_q [BFLY_LAT];
    wr_t             pipe_d [BFLY_LAT];

    logic              stall_w;
    logic              issue;
    logic [N_LOG2-1:0] rd_a, rd_b;
    logic [TW_W-1:0]   tw;
    wr_t               wr_out;

`ifdef FFT_SEQ_AGU_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif

    function automatic logic [N_LOG2-1:0] rotl(input logic [N_LOG2-1:0] x,
                                               input logic [S_W-1:0]    sh);
        logic [2*N_LOG2-1:0] t;
        t = {x, x} << sh;
        return t[2*N_LOG2-1 -: N_LOG2];
    endfunction

    // Keeps the top sh bits of the twiddle field; sh never exceeds TW_W.
    function automatic logic [TW_W-1:0] tw_mask(input logic [S_W-1:0] sh);
        logic [TW_W-1:0] ones;
        ones = '1;
        return ~(ones >> sh);
    endfunction

    assign issue = (state_q == ST_RUN);
    assign rd_a  = issue ? rotl({i_q, 1'b0}, s_q) : '0;
    assign rd_b  = issue ? rotl({i_q, 1'b1}, s_q) : '0;
    assign tw    = issue ? (i_q & tw_mask(s_q)) : '0;

    // The final stage drains one cycle short: DONE is the cycle its last write is issued.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        rdsel_d = rdsel_q;
        if (!stall_w) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                        s_d     = '0;
                        i_d     = '0;
                        rdsel_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_q == I_LAST) begin
                        cnt_d = '0;
                        if (s_q == S_LAST && BFLY_LAT == 1) state_d = ST_DONE;
                        else                                state_d = ST_DRAIN;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (s_q == S_LAST) begin
                        if (cnt_q == CNT_FIN_END) state_d = ST_DONE;
                        else                      cnt_d   = cnt_q + 1'b1;
                    end else if (cnt_q == CNT_MID_END) begin
                        state_d = ST_RUN;
                        s_d     = s_q + 1'b1;
                        i_d     = '0;
                        rdsel_d = s_d[0];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < BFLY_LAT; k++) pipe_d[k] = pipe_q[k];
        if (!stall_w) begin
            pipe_d[0] = '{vld: issue, bank: ~rdsel_q, a: rd_a, b: rd_b};
            for (int k = 1; k < BFLY_LAT; k++) pipe_d[k] = pipe_q[k-1];
        end
    end

    // NOTE: the write pipeline is reset along with the FSM so an aborted run
    // cannot leave a stale write enable queued behind the reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            rdsel_q <= 1'b0;
            for (int k = 0; k < BFLY_LAT; k++) pipe_q[k] <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            rdsel_q <= rdsel_d;
            for (int k = 0; k < BFLY_LAT; k++) pipe_q[k] <= pipe_d[k];
        end
    end

    assign wr_out = pipe_q[BFLY_LAT-1];

    assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.rdsel      = rdsel_q;
    assign bus.adra_rd    = rd_a;
    assign bus.adrb_rd    = rd_b;
    assign bus.twiddleadr = tw;
    assign bus.we0        = wr_out.vld && !wr_out.bank && !stall_w;
    assign bus.we1        = wr_out.vld &&  wr_out.bank && !stall_w;
    assign bus.adra_wr    = wr_out.a;
    assign bus.adrb_wr    = wr_out.b;
    assign bus.outsel     = 1'(N_LOG2 % 2);

    a_we_exclusive: assert property (@(posedge clk) disable iff (reset) !(bus.we0 && bus.we1));

endmodule
